// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM encoding, counter sizing
// and the lowest-set-bit search used to find the most fundamental request.
package reset_seq_pkg;

    localparam logic [1:0] ST_HOLD    = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;

    typedef enum logic [1:0] {
        SEQ_HOLD    = ST_HOLD,
        SEQ_RELEASE = ST_RELEASE,
        SEQ_RUN     = ST_RUN
    } seq_state_e;

    // Wide enough to count up to the longer of the pulse stretch and the gap.
    function automatic int cntWidth(input int minPulse, input int releaseGap);
        int longest;
        longest = (minPulse > releaseGap) ? minPulse : releaseGap;
        return (longest < 1) ? 1 : $clog2(longest + 1);
    endfunction

    // Returns 32 when no bit is set; callers only use it with a nonzero vector.
    function automatic int lowestSet(input logic [31:0] vec);
        int idx;
        idx = 32;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/reset_sequencer_sync_chain.sv
// Single-bit flop chain that brings an unrelated reset request into the clk
// domain; clears to the "no request" level while rst_n is low.
module sync_chain #(
    parameter int   Stages     = 2,
    parameter logic ResetValue = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [Stages-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_chain <= {Stages{ResetValue}};
        end else begin
            r_chain <= {r_chain[Stages-2:0], i_async};
        end
    end

    assign o_sync = r_chain[Stages-1];

endmodule

// File: rtl/reset_sequencer.sv
// Multi-domain reset synchroniser and sequencer: stretches every request to a
// minimum width, then releases domains one by one in dependency order.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int Channels       = 4,
    parameter int SyncStages     = 2,
    parameter int MinPulse       = 16,
    parameter int ReleaseGap     = 8,
    parameter int InputPolarity  = 0,
    parameter int OutputPolarity = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [Channels-1:0] req_in,
    input  logic                sw_rst,
    output logic [Channels-1:0] rst_out,
    output logic                ready,
    output logic                busy
);

    localparam int CntW       = cntWidth(MinPulse, ReleaseGap);
    localparam int BaseW      = $clog2(Channels + 1);
    localparam int GapLastInt = (ReleaseGap > 0) ? ReleaseGap - 1 : 0;

    localparam logic [CntW-1:0]     HoldLast  = CntW'(MinPulse - 1);
    localparam logic [CntW-1:0]     GapLast   = CntW'(GapLastInt);
    localparam logic [BaseW-1:0]    BaseAll   = BaseW'(Channels);
    localparam logic [BaseW-1:0]    LastChan  = BaseW'(Channels - 1);
    localparam logic                IdleLevel = (InputPolarity != 0) ? 1'b0 : 1'b1;
    localparam logic [Channels-1:0] OutInvert = (OutputPolarity != 0) ? {Channels{1'b0}}
                                                                     : {Channels{1'b1}};

    logic [1:0]          r_state;
    logic [BaseW-1:0]    r_base;
    logic [CntW-1:0]     r_cnt;
    logic [Channels-1:0] r_rstOut;
    logic                r_ready;
    logic                r_busy;

    logic [Channels-1:0] w_sync;
    logic [Channels-1:0] w_req;
    logic [BaseW-1:0]    w_lowReq;
    logic [BaseW-1:0]    w_effBase;
    logic [1:0]          w_nextState;
    logic [BaseW-1:0]    w_nextBase;
    logic [CntW-1:0]     w_nextCnt;
    logic [Channels-1:0] w_heldNext;

    for (genvar g = 0; g < Channels; g++) begin : g_sync
        sync_chain #(
            .Stages     (SyncStages),
            .ResetValue (IdleLevel)
        ) u_sync (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_async (req_in[g]),
            .o_sync  (w_sync[g])
        );
    end

    assign w_req     = ((InputPolarity != 0) ? w_sync : ~w_sync) | {Channels{sw_rst}};
    assign w_lowReq  = BaseW'(lowestSet(32'(w_req)));
    assign w_effBase = (r_state == ST_RUN) ? BaseAll : r_base;

    // A live request always wins over any release scheduled for this edge.
    always_comb begin
        w_nextState = r_state;
        w_nextBase  = r_base;
        w_nextCnt   = r_cnt;
        if (w_req != '0) begin
            w_nextBase  = (w_lowReq < w_effBase) ? w_lowReq : w_effBase;
            w_nextCnt   = '0;
            w_nextState = ST_HOLD;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_cnt == HoldLast) begin
                        w_nextCnt = '0;
                        if (ReleaseGap == 0 || r_base == LastChan) begin
                            w_nextBase  = BaseAll;
                            w_nextState = ST_RUN;
                        end else begin
                            w_nextBase  = r_base + 1'b1;
                            w_nextState = ST_RELEASE;
                        end
                    end else begin
                        w_nextCnt = r_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (ReleaseGap == 0 || r_cnt == GapLast) begin
                        w_nextCnt = '0;
                        if (r_base == LastChan) begin
                            w_nextBase  = BaseAll;
                            w_nextState = ST_RUN;
                        end else begin
                            w_nextBase = r_base + 1'b1;
                        end
                    end else begin
                        w_nextCnt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_nextBase = BaseAll;
                end
            endcase
        end
    end

    // Every channel at or above the lowest still-held index stays in reset.
    always_comb begin
        w_heldNext = '0;
        for (int i = 0; i < Channels; i++) begin
            w_heldNext[i] = (w_nextState != ST_RUN) && (BaseW'(i) >= w_nextBase);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_HOLD;
            r_base   <= '0;
            r_cnt    <= '0;
            r_rstOut <= {Channels{1'b1}} ^ OutInvert;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
        end else begin
            r_state  <= w_nextState;
            r_base   <= w_nextBase;
            r_cnt    <= w_nextCnt;
            r_rstOut <= w_heldNext ^ OutInvert;
            r_ready  <= (w_nextState == ST_RUN);
            r_busy   <= (w_nextState != ST_RUN);
        end
    end

    assign rst_out = r_rstOut;
    assign ready   = r_ready;
    assign busy    = r_busy;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a default instance and a wide zero-gap instance
// with inverted polarities, both compared every cycle against a schedule model.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sw_rst;
    logic [3:0] reqA;
    logic [7:0] reqB;
    logic [3:0] rstOutA;
    logic [7:0] rstOutB;
    logic       readyA, busyA, readyB, busyB;

    localparam logic [3:0] IdleA = 4'hF;
    localparam logic [7:0] IdleB = 8'h00;

    int checks = 0;
    int errors = 0;
    int edgeCount = 0;

    int pCh[2]     = '{4, 8};
    int pSs[2]     = '{2, 3};
    int pMp[2]     = '{16, 16};
    int pGap[2]    = '{8, 0};
    int pInPol[2]  = '{0, 1};
    int pOutPol[2] = '{1, 0};

    logic [7:0] syncPipe[2][4];
    int         b0[2];
    int         quiet[2];

    always #5 clk = ~clk;

    reset_sequencer #(
        .Channels(4), .SyncStages(2), .MinPulse(16), .ReleaseGap(8),
        .InputPolarity(0), .OutputPolarity(1)
    ) dutA (
        .clk(clk), .rst_n(rst_n), .req_in(reqA), .sw_rst(sw_rst),
        .rst_out(rstOutA), .ready(readyA), .busy(busyA)
    );

    reset_sequencer #(
        .Channels(8), .SyncStages(3), .MinPulse(16), .ReleaseGap(0),
        .InputPolarity(1), .OutputPolarity(0)
    ) dutB (
        .clk(clk), .rst_n(rst_n), .req_in(reqB), .sw_rst(sw_rst),
        .rst_out(rstOutB), .ready(readyB), .busy(busyB)
    );

    function automatic logic [7:0] chMask(input int m);
        logic [7:0] full;
        full = 8'hFF;
        return full >> (8 - pCh[m]);
    endfunction

    // Channel b0+k is free once the quiet run reaches MinPulse + k*ReleaseGap.
    function automatic int curBase(input int m);
        int cb;
        cb = b0[m];
        for (int i = b0[m]; i < pCh[m]; i++) begin
            if (quiet[m] >= pMp[m] + (i - b0[m]) * pGap[m]) begin
                cb = i + 1;
            end
        end
        return cb;
    endfunction

    function automatic logic [7:0] expOut(input int m);
        logic [7:0] held;
        int cb;
        cb   = curBase(m);
        held = 8'h00;
        for (int i = 0; i < pCh[m]; i++) begin
            held[i] = (i >= cb);
        end
        return (pOutPol[m] != 0) ? held : (~held & chMask(m));
    endfunction

    task automatic modelEdge(input int m, input bit rstN, input logic [7:0] raw, input bit sw);
        logic [7:0] mask, sOld, r;
        int j, cb;
        mask = chMask(m);
        if (!rstN) begin
            for (int k = 0; k < 4; k++) syncPipe[m][k] = 8'h00;
            b0[m]    = 0;
            quiet[m] = 0;
        end else begin
            sOld = syncPipe[m][pSs[m]-1];
            for (int k = 3; k > 0; k--) syncPipe[m][k] = syncPipe[m][k-1];
            syncPipe[m][0] = ((pInPol[m] != 0) ? raw : ~raw) & mask;
            r = sOld | (sw ? mask : 8'h00);
            if (r != 8'h00) begin
                j = 8;
                for (int i = 7; i >= 0; i--) if (r[i]) j = i;
                cb       = curBase(m);
                b0[m]    = (j < cb) ? j : cb;
                quiet[m] = 0;
            end else begin
                quiet[m]++;
            end
        end
    endtask

    task automatic checkOutput();
        logic [7:0] eA8, eB;
        logic [3:0] eA;
        logic       rdyA, rdyB;
        eA8  = expOut(0);
        eA   = eA8[3:0];
        eB   = expOut(1);
        rdyA = (curBase(0) == 4);
        rdyB = (curBase(1) == 8);
        checks++;
        assert (rstOutA === eA) else begin
            errors++;
            $error("[TB] FAIL rstOutA edge=%0d observed=%b expected=%b", edgeCount, rstOutA, eA);
        end
        checks++;
        assert (readyA === rdyA) else begin
            errors++;
            $error("[TB] FAIL readyA edge=%0d observed=%b expected=%b", edgeCount, readyA, rdyA);
        end
        checks++;
        assert (busyA === !rdyA) else begin
            errors++;
            $error("[TB] FAIL busyA edge=%0d observed=%b expected=%b", edgeCount, busyA, !rdyA);
        end
        checks++;
        assert (rstOutB === eB) else begin
            errors++;
            $error("[TB] FAIL rstOutB edge=%0d observed=%b expected=%b", edgeCount, rstOutB, eB);
        end
        checks++;
        assert (readyB === rdyB) else begin
            errors++;
            $error("[TB] FAIL readyB edge=%0d observed=%b expected=%b", edgeCount, readyB, rdyB);
        end
        checks++;
        assert (busyB === !rdyB) else begin
            errors++;
            $error("[TB] FAIL busyB edge=%0d observed=%b expected=%b", edgeCount, busyB, !rdyB);
        end
    endtask

    task automatic checkDirected(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s edge=%0d observed=%b expected=%b", tag, edgeCount, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit rstN, input logic [3:0] rA, input logic [7:0] rB, input bit sw);
        rst_n  = rstN;
        reqA   = rA;
        reqB   = rB;
        sw_rst = sw;
        @(posedge clk);
        modelEdge(0, rstN, {4'h0, rA}, sw);
        modelEdge(1, rstN, rB, sw);
        #1;
        edgeCount++;
        checkOutput();
    endtask

    initial begin
        logic [3:0] rndA;
        logic [7:0] rndB;
        bit         rndSw, rndRst;

        rst_n = 1'b0; sw_rst = 1'b0; reqA = IdleA; reqB = IdleB;

        // Power-up: default schedule 16/24/32/40, wide instance all at 16.
        repeat (5) applyStimulus(1'b0, IdleA, IdleB, 1'b0);
        checkDirected("resetA", {4'h0, rstOutA}, 8'h0F);
        checkDirected("resetB", rstOutB, 8'h00);
        for (int e = 1; e <= 40; e++) begin
            applyStimulus(1'b1, IdleA, IdleB, 1'b0);
            if (e == 15) checkDirected("b6Held", rstOutB, 8'h00);
            if (e == 16) checkDirected("b6AllClear", rstOutB, 8'hFF);
            if (e == 16) checkDirected("a0Clear", {4'h0, rstOutA}, 8'h0E);
            if (e == 39) checkDirected("aReadyLow", {7'h0, readyA}, 8'h00);
            if (e == 40) checkDirected("aReadyHigh", {7'h0, readyA}, 8'h01);
        end

        // Partial reset from RUN on A channel 2; 4-edge latency on B channel 5.
        for (int e = 1; e <= 30; e++) begin
            applyStimulus(1'b1, (e == 1) ? 4'b1011 : IdleA, (e == 1) ? 8'h20 : IdleB, 1'b0);
            if (e == 3)  checkDirected("partialAssert", {4'h0, rstOutA}, 8'h0C);
            if (e == 18) checkDirected("partialHold2", {4'h0, rstOutA}, 8'h0C);
            if (e == 19) checkDirected("partialRel2", {4'h0, rstOutA}, 8'h08);
            if (e == 27) checkDirected("partialRel3", {4'h0, rstOutA}, 8'h00);
            if (e == 3)  checkDirected("bLatencyPre", rstOutB, 8'hFF);
            if (e == 4)  checkDirected("bLatency", rstOutB, 8'h1F);
            if (e == 19) checkDirected("bHold", rstOutB, 8'h1F);
            if (e == 20) checkDirected("bRelease", rstOutB, 8'hFF);
        end

        // Software reset mid-release restarts the full schedule.
        repeat (3) applyStimulus(1'b0, IdleA, IdleB, 1'b0);
        repeat (20) applyStimulus(1'b1, IdleA, IdleB, 1'b0);
        applyStimulus(1'b1, IdleA, IdleB, 1'b1);
        checkDirected("swEscalate", {4'h0, rstOutA}, 8'h0F);
        for (int e = 1; e <= 40; e++) begin
            applyStimulus(1'b1, IdleA, IdleB, 1'b0);
            if (e == 15) checkDirected("swHold0", {4'h0, rstOutA}, 8'h0F);
            if (e == 16) checkDirected("swRel0", {4'h0, rstOutA}, 8'h0E);
        end

        // Long request on channel 1 stretches bits 3:1.
        repeat (50) applyStimulus(1'b1, 4'b1101, IdleB, 1'b0);
        for (int e = 1; e <= 45; e++) begin
            applyStimulus(1'b1, IdleA, IdleB, 1'b0);
            if (e == 17) checkDirected("longHold", {4'h0, rstOutA}, 8'h0E);
            if (e == 18) checkDirected("longRel1", {4'h0, rstOutA}, 8'h0C);
        end

        // Channel 3 request lands exactly on the bit-2 release edge.
        applyStimulus(1'b1, IdleA, IdleB, 1'b1);
        repeat (29) applyStimulus(1'b1, IdleA, IdleB, 1'b0);
        applyStimulus(1'b1, 4'b0111, IdleB, 1'b0);
        repeat (2) applyStimulus(1'b1, IdleA, IdleB, 1'b0);
        checkDirected("collisionHold", {4'h0, rstOutA}, 8'h0C);
        for (int e = 1; e <= 40; e++) begin
            applyStimulus(1'b1, IdleA, IdleB, 1'b0);
            if (e == 15) checkDirected("collisionRestart", {4'h0, rstOutA}, 8'h0C);
            if (e == 16) checkDirected("collisionRel2", {4'h0, rstOutA}, 8'h08);
        end

        // Random bursts of requests, software resets and rst_n, then quiet runs.
        for (int round = 0; round < 8; round++) begin
            for (int c = 0; c < 80; c++) begin
                rndA = 4'h0;
                rndB = 8'h00;
                for (int i = 0; i < 4; i++) rndA[i] = ($urandom_range(0, 23) == 0);
                for (int i = 0; i < 8; i++) rndB[i] = ($urandom_range(0, 31) == 0);
                rndSw  = ($urandom_range(0, 59) == 0);
                rndRst = ($urandom_range(0, 199) == 0);
                applyStimulus(!rndRst, ~rndA, rndB, rndSw);
            end
            repeat (60) applyStimulus(1'b1, IdleA, IdleB, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
